// File: rtl/hazard_stall_unit.sv
// Load-use / branch-dependency stall controller for an ID-resolved-branch pipeline.
// Optional stall statistics outputs are enabled by defining HAZARD_STATS_EN.
module hazard_stall_unit #(
  parameter int REG_ADDR_W         = 5,
  parameter int LOAD_USE_STALLS    = 1,
  parameter int LOAD_BRANCH_STALLS = 2,
  parameter int ALU_BRANCH_STALLS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_id,
  input  logic [REG_ADDR_W-1:0] rs_id,
  input  logic [REG_ADDR_W-1:0] rt_id,
  input  logic                  uses_rs_id,
  input  logic                  uses_rt_id,
  input  logic                  is_branch_id,
  input  logic [REG_ADDR_W-1:0] rd_ex,
  input  logic                  reg_write_ex,
  input  logic                  mem_read_ex,
  input  logic [REG_ADDR_W-1:0] rd_mem,
  input  logic                  mem_read_mem,
  input  logic                  flush,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  noop,
  output logic                  stall_busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]           stall_cycles,
  output logic [15:0]           hazard_events
`endif
);

  localparam logic [2:0] LU_N = 3'(LOAD_USE_STALLS);
  localparam logic [2:0] LB_N = 3'(LOAD_BRANCH_STALLS);
  localparam logic [2:0] AB_N = 3'(ALU_BRANCH_STALLS);

  typedef enum logic {IDLE, STALL} state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] luN, ebN, mbN, needN;
  logic       exMatch, memMatch, stall;

  // Register zero is never a real dependency, so it is excluded from matching.
  assign exMatch  = (uses_rs_id && (rs_id != '0) && (rs_id == rd_ex)) ||
                    (uses_rt_id && (rt_id != '0) && (rt_id == rd_ex));
  assign memMatch = (uses_rs_id && (rs_id != '0) && (rs_id == rd_mem)) ||
                    (uses_rt_id && (rt_id != '0) && (rt_id == rd_mem));

  always_comb begin
    luN   = (valid_id && mem_read_ex && exMatch) ? LU_N : 3'd0;
    ebN   = (valid_id && is_branch_id && reg_write_ex && exMatch) ?
            (mem_read_ex ? LB_N : AB_N) : 3'd0;
    mbN   = (valid_id && is_branch_id && mem_read_mem && memMatch) ? 3'd1 : 3'd0;
    needN = luN;
    if (ebN > needN) needN = ebN;
    if (mbN > needN) needN = mbN;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (needN != 3'd0) begin
            stall = 1'b1;
            if (needN > 3'd1) begin
              state_d = STALL;
              cnt_d   = needN - 3'd1;
            end
          end
        end
        STALL: begin
          stall = 1'b1;
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset must win over a hazard pattern that happens to be on the inputs.
  assign pc_write    = ~(stall & ~rst);
  assign if_id_write = ~(stall & ~rst);
  assign noop        = stall & ~rst;
  assign stall_busy  = (state_q == STALL);

`ifdef HAZARD_STATS_EN
  logic [15:0] stallCycles_q, hazardEvents_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCycles_q  <= 16'd0;
      hazardEvents_q <= 16'd0;
    end else begin
      if (stall && (stallCycles_q != 16'hFFFF))
        stallCycles_q <= stallCycles_q + 16'd1;
      if (stall && (state_q == IDLE) && (hazardEvents_q != 16'hFFFF))
        hazardEvents_q <= hazardEvents_q + 16'd1;
    end
  end

  assign stall_cycles  = stallCycles_q;
  assign hazard_events = hazardEvents_q;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed testbench for hazard_stall_unit: a default instance plus one with LOAD_BRANCH_STALLS=4.
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_id, uses_rs_id, uses_rt_id, is_branch_id;
  logic [4:0] rs_id, rt_id, rd_ex, rd_mem;
  logic       reg_write_ex, mem_read_ex, mem_read_mem, flush;
  logic       pcW, ifW, noop, busy;
  logic       pcW4, ifW4, noop4, busy4;
  int         checks = 0;
  int         passed = 0;
`ifdef HAZARD_STATS_EN
  logic [15:0] stallCycles, hazardEvents, stallCycles4, hazardEvents4;
`endif

  wire [3:0] obs  = {pcW, ifW, noop, busy};
  wire [3:0] obs4 = {pcW4, ifW4, noop4, busy4};

  // {pc_write, if_id_write, noop, stall_busy}
  localparam logic [3:0] RUN    = 4'b1100;
  localparam logic [3:0] BUB1   = 4'b0010;
  localparam logic [3:0] BUBS   = 4'b0011;
  localparam logic [3:0] FLUSHS = 4'b1101;

  always #5 clk = ~clk;

  hazard_stall_unit dut (
    .clk(clk), .rst(rst), .valid_id(valid_id), .rs_id(rs_id), .rt_id(rt_id),
    .uses_rs_id(uses_rs_id), .uses_rt_id(uses_rt_id), .is_branch_id(is_branch_id),
    .rd_ex(rd_ex), .reg_write_ex(reg_write_ex), .mem_read_ex(mem_read_ex),
    .rd_mem(rd_mem), .mem_read_mem(mem_read_mem), .flush(flush),
    .pc_write(pcW), .if_id_write(ifW), .noop(noop), .stall_busy(busy)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(stallCycles), .hazard_events(hazardEvents)
`endif
  );

  hazard_stall_unit #(.LOAD_BRANCH_STALLS(4)) dut4 (
    .clk(clk), .rst(rst), .valid_id(valid_id), .rs_id(rs_id), .rt_id(rt_id),
    .uses_rs_id(uses_rs_id), .uses_rt_id(uses_rt_id), .is_branch_id(is_branch_id),
    .rd_ex(rd_ex), .reg_write_ex(reg_write_ex), .mem_read_ex(mem_read_ex),
    .rd_mem(rd_mem), .mem_read_mem(mem_read_mem), .flush(flush),
    .pc_write(pcW4), .if_id_write(ifW4), .noop(noop4), .stall_busy(busy4)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(stallCycles4), .hazard_events(hazardEvents4)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    valid_id = 1'b0; uses_rs_id = 1'b0; uses_rt_id = 1'b0; is_branch_id = 1'b0;
    rs_id = 5'd0; rt_id = 5'd0; rd_ex = 5'd0; rd_mem = 5'd0;
    reg_write_ex = 1'b0; mem_read_ex = 1'b0; mem_read_mem = 1'b0; flush = 1'b0;
  endtask

  task automatic loadUseInputs();
    idleInputs();
    valid_id = 1'b1; mem_read_ex = 1'b1; reg_write_ex = 1'b1;
    rd_ex = 5'd5; rs_id = 5'd5; uses_rs_id = 1'b1;
  endtask

  task automatic loadBranchInputs();
    idleInputs();
    valid_id = 1'b1; is_branch_id = 1'b1; mem_read_ex = 1'b1; reg_write_ex = 1'b1;
    rd_ex = 5'd8; rt_id = 5'd8; uses_rt_id = 1'b1;
  endtask

  task automatic test_reset();
    loadUseInputs();
    rst = 1'b1;
    #1;
    checks++; if (obs !== RUN) $display("[TB] FAIL reset_outputs: got %b expected %b", obs, RUN); else passed++;
    checks++; if (obs4 !== RUN) $display("[TB] FAIL reset_outputs4: got %b expected %b", obs4, RUN); else passed++;
`ifdef HAZARD_STATS_EN
    checks++; if ({stallCycles, hazardEvents} !== 32'd0)
      $display("[TB] FAIL reset_stats: got %h expected 0", {stallCycles, hazardEvents}); else passed++;
`endif
    tick();
    rst = 1'b0;
    idleInputs();
    #1;
    checks++; if (obs !== RUN) $display("[TB] FAIL post_reset_idle: got %b expected %b", obs, RUN); else passed++;
  endtask

  task automatic test_load_use();
    loadUseInputs();
    #1;
    checks++; if (obs !== BUB1) $display("[TB] FAIL load_use_c1: got %b expected %b", obs, BUB1); else passed++;
    tick();
    idleInputs();
    #1;
    checks++; if (obs !== RUN) $display("[TB] FAIL load_use_c2: got %b expected %b", obs, RUN); else passed++;
    tick();
  endtask

  task automatic test_load_branch();
    loadBranchInputs();
    #1;
    checks++; if (obs !== BUB1) $display("[TB] FAIL load_branch_c1: got %b expected %b", obs, BUB1); else passed++;
    tick();
    // Inputs deliberately held: STALL ignores them.
    #1;
    checks++; if (obs !== BUBS) $display("[TB] FAIL load_branch_c2: got %b expected %b", obs, BUBS); else passed++;
    tick();
    idleInputs();
    #1;
    checks++; if (obs !== RUN) $display("[TB] FAIL load_branch_c3: got %b expected %b", obs, RUN); else passed++;
    tick();
  endtask

  task automatic test_other_hazards();
    idleInputs();
    valid_id = 1'b1; is_branch_id = 1'b1; reg_write_ex = 1'b1; rd_ex = 5'd3; rs_id = 5'd3; uses_rs_id = 1'b1;
    #1;
    checks++; if (obs !== BUB1) $display("[TB] FAIL alu_branch_c1: got %b expected %b", obs, BUB1); else passed++;
    tick();
    idleInputs();
    valid_id = 1'b1; is_branch_id = 1'b1; mem_read_mem = 1'b1; rd_mem = 5'd9; rt_id = 5'd9; uses_rt_id = 1'b1;
    #1;
    checks++; if (obs !== BUB1) $display("[TB] FAIL mem_branch_c1: got %b expected %b", obs, BUB1); else passed++;
    tick();
    idleInputs();
    #1;
    checks++; if (obs !== RUN) $display("[TB] FAIL mem_branch_c2: got %b expected %b", obs, RUN); else passed++;
    tick();
  endtask

  task automatic test_no_hazard();
    loadUseInputs();
    rd_ex = 5'd0; rs_id = 5'd0;
    #1;
    checks++; if (obs !== RUN) $display("[TB] FAIL reg_zero_load: got %b expected %b", obs, RUN); else passed++;
    loadBranchInputs();
    rd_ex = 5'd0; rt_id = 5'd0;
    #1;
    checks++; if (obs !== RUN) $display("[TB] FAIL reg_zero_branch: got %b expected %b", obs, RUN); else passed++;
    loadUseInputs();
    valid_id = 1'b0;
    #1;
    checks++; if (obs !== RUN) $display("[TB] FAIL invalid_id: got %b expected %b", obs, RUN); else passed++;
    loadUseInputs();
    uses_rs_id = 1'b0;
    #1;
    checks++; if (obs !== RUN) $display("[TB] FAIL unused_src: got %b expected %b", obs, RUN); else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    loadUseInputs();
    #1;
    checks++; if (obs !== BUB1) $display("[TB] FAIL b2b_c1: got %b expected %b", obs, BUB1); else passed++;
    tick();
    #1;
    checks++; if (obs !== BUB1) $display("[TB] FAIL b2b_c2: got %b expected %b", obs, BUB1); else passed++;
    tick();
    idleInputs();
    #1;
    checks++; if (obs !== RUN) $display("[TB] FAIL b2b_c3: got %b expected %b", obs, RUN); else passed++;
    tick();
  endtask

  task automatic test_flush();
    loadUseInputs();
    flush = 1'b1;
    #1;
    checks++; if (obs !== RUN) $display("[TB] FAIL flush_idle: got %b expected %b", obs, RUN); else passed++;
    tick();
    loadBranchInputs();
    #1;
    checks++; if (obs4 !== BUB1) $display("[TB] FAIL flush_stall_c1: got %b expected %b", obs4, BUB1); else passed++;
    tick();
    flush = 1'b1;
    #1;
    checks++; if (obs4 !== FLUSHS) $display("[TB] FAIL flush_stall_c2: got %b expected %b", obs4, FLUSHS); else passed++;
    tick();
    idleInputs();
    #1;
    checks++; if (obs4 !== RUN) $display("[TB] FAIL flush_stall_c3: got %b expected %b", obs4, RUN); else passed++;
    tick();
  endtask

  task automatic test_reset_mid_stall();
    loadBranchInputs();
    tick();
    checks++; if (obs4 !== BUBS) $display("[TB] FAIL rst_mid_pre: got %b expected %b", obs4, BUBS); else passed++;
    rst = 1'b1;
    #1;
    checks++; if (obs4 !== RUN) $display("[TB] FAIL rst_mid_async: got %b expected %b", obs4, RUN); else passed++;
    tick();
    rst = 1'b0;
    idleInputs();
    #1;
    checks++; if (obs4 !== RUN) $display("[TB] FAIL rst_mid_after1: got %b expected %b", obs4, RUN); else passed++;
    tick();
    checks++; if (obs4 !== RUN) $display("[TB] FAIL rst_mid_after2: got %b expected %b", obs4, RUN); else passed++;
  endtask

`ifdef HAZARD_STATS_EN
  task automatic test_stats();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      loadBranchInputs();
      tick();
      tick();
      idleInputs();
      tick();
    end
    checks++; if (hazardEvents !== 16'd3) $display("[TB] FAIL stats_events: got %0d expected 3", hazardEvents); else passed++;
    checks++; if (stallCycles !== 16'd6) $display("[TB] FAIL stats_cycles: got %0d expected 6", stallCycles); else passed++;
  endtask
`endif

  initial begin
    rst = 1'b1;
    idleInputs();
    #12;
    test_reset();
    test_load_use();
    test_load_branch();
    test_other_hazards();
    test_no_hazard();
    test_back_to_back();
    test_flush();
    test_reset_mid_stall();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
